pla_in6_bist: RTL and testbench

PLA_IN6_BIST -- requirements
Module: pla_in6_bist

---
 rtl/pla_in6_bist.sv | 80 ++++++++
 tb/tb_pla_in6_bist.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/pla_in6_bist.sv
// pla_in6_bist: drives LFSR vectors onto the in6 PLA inputs and compacts the
// responses into a MISR signature.
module pla_in6_bist #(
    parameter int VEC_W = 33,
    parameter int RSP_W = 23,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [VEC_W-1:0] seed,
    input  logic [CNT_W-1:0] count,
    output logic [VEC_W-1:0] x,
    input  logic [RSP_W-1:0] z,
    output logic             busy,
    output logic             done,
    output logic [RSP_W-1:0] signature,
    output logic [CNT_W-1:0] vec_idx
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_n;
    logic [VEC_W-1:0] x_n;
    logic [RSP_W-1:0] sig_n;
    logic [CNT_W-1:0] rem, rem_n, idx_n;
    always_comb begin
        state_n = state;
        x_n = x;
        sig_n = signature;
        rem_n = rem;
        idx_n = vec_idx;
        case (state)
            IDLE: if (start) begin
                sig_n = '0;
                idx_n = '0;
                if (count == '0) state_n = DONE;
                else begin
                    state_n = RUN;
                    // an all-zero LFSR would lock up, so substitute 1
                    x_n = (seed == '0) ? VEC_W'(1) : seed;
                    rem_n = count;
                end
            end
            RUN: if (abort) begin
                state_n = IDLE;
                x_n = '0;
                idx_n = '0;
                rem_n = '0;
            end else begin
                sig_n = {signature[RSP_W-2:0], signature[RSP_W-1] ^ signature[RSP_W-6]} ^ z;
                rem_n = rem - CNT_W'(1);
                if (rem == CNT_W'(1)) begin
                    state_n = DONE;
                    x_n = '0;
                end else begin
                    x_n = {x[VEC_W-2:0], x[VEC_W-1] ^ x[VEC_W-14]};
                    idx_n = vec_idx + CNT_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            x <= '0;
            signature <= '0;
            rem <= '0;
            vec_idx <= '0;
        end else begin
            state <= state_n;
            x <= x_n;
            signature <= sig_n;
            rem <= rem_n;
            vec_idx <= idx_n;
        end
    end
    assign busy = (state == RUN);
    assign done = (state == DONE);
endmodule

// File: tb/tb_pla_in6_bist.sv
// tb_pla_in6_bist: randomized self-checking bench for pla_in6_bist against a
// behavioural vector/signature model and a stand-in PLA response function.
module tb_pla_in6_bist;
    logic        clk = 0;
    logic        rst = 1;
    logic        start = 0;
    logic        abort = 0;
    logic [32:0] seed = '0;
    logic [15:0] count = '0;
    logic [32:0] x;
    logic [22:0] z;
    logic        busy, done;
    logic [22:0] signature;
    logic [15:0] vec_idx;
    logic        z_pla = 0;
    logic [22:0] z_const = '0;
    int nchk = 0;
    int nerr = 0;

    pla_in6_bist dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .seed(seed), .count(count),
        .x(x), .z(z), .busy(busy), .done(done), .signature(signature), .vec_idx(vec_idx)
    );

    always #5 clk = ~clk;

    // arbitrary combinational 33-in/23-out function standing in for the PLA
    function automatic logic [22:0] pla(input logic [32:0] v);
        return v[22:0] ^ {v[32:23], v[32:20]} ^ {v[10:0], v[32:21]} ^ {23{v[5] & v[17]}};
    endfunction

    assign z = z_pla ? pla(x) : z_const;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [22:0] misr(input logic [22:0] s, input logic [22:0] r);
        logic [22:0] t;
        t = (s << 1) | 23'(s[22] ^ s[17]);
        return t ^ r;
    endfunction

    function automatic logic [32:0] lfsr(input logic [32:0] v);
        logic [32:0] t;
        t = (v << 1) | 33'(v[32] ^ v[19]);
        return t;
    endfunction

    task automatic run_check(input logic [32:0] s, input logic [15:0] c, input bit use_pla,
                             output logic [22:0] sig_out);
        logic [32:0] xe;
        logic [22:0] sig;
        seed = s;
        count = c;
        z_pla = use_pla;
        start = 1;
        step;
        start = 0;
        xe = (s == 0) ? 33'd1 : s;
        sig = '0;
        if (c == 0) begin
            nchk++; if (busy !== 1'b0) begin nerr++; $display("FAIL cnt0_busy: got %b expected 0", busy); end
            nchk++; if (done !== 1'b1) begin nerr++; $display("FAIL cnt0_done: got %b expected 1", done); end
            nchk++; if (signature !== 23'h0) begin nerr++; $display("FAIL cnt0_sig: got %h expected 0", signature); end
            nchk++; if (x !== 33'h0) begin nerr++; $display("FAIL cnt0_x: got %h expected 0", x); end
            step;
            nchk++; if (done !== 1'b0) begin nerr++; $display("FAIL cnt0_done_pulse: got %b expected 0", done); end
            sig_out = '0;
            return;
        end
        for (int i = 0; i < int'(c); i++) begin
            nchk++; if (x !== xe) begin nerr++; $display("FAIL run_x[%0d]: got %h expected %h", i, x, xe); end
            nchk++; if (vec_idx !== 16'(i)) begin nerr++; $display("FAIL run_idx[%0d]: got %0d expected %0d", i, vec_idx, i); end
            nchk++; if (busy !== 1'b1) begin nerr++; $display("FAIL run_busy[%0d]: got %b expected 1", i, busy); end
            nchk++; if (done !== 1'b0) begin nerr++; $display("FAIL run_done[%0d]: got %b expected 0", i, done); end
            sig = misr(sig, use_pla ? pla(xe) : z_const);
            xe = lfsr(xe);
            start = 1'($urandom);
            seed = {1'($urandom), 32'($urandom)};
            count = 16'($urandom);
            step;
        end
        start = 0;
        nchk++; if (done !== 1'b1) begin nerr++; $display("FAIL end_done: got %b expected 1", done); end
        nchk++; if (busy !== 1'b0) begin nerr++; $display("FAIL end_busy: got %b expected 0", busy); end
        nchk++; if (x !== 33'h0) begin nerr++; $display("FAIL end_x: got %h expected 0", x); end
        nchk++; if (signature !== sig) begin nerr++; $display("FAIL end_sig: got %h expected %h", signature, sig); end
        step;
        nchk++; if (done !== 1'b0 || busy !== 1'b0) begin nerr++; $display("FAIL after_done: got done=%b busy=%b expected 0 0", done, busy); end
        nchk++; if (signature !== sig) begin nerr++; $display("FAIL sig_hold: got %h expected %h", signature, sig); end
        sig_out = sig;
    endtask

    task automatic test_reset;
        repeat (2) step;
        nchk++; if (x !== 33'h0 || signature !== 23'h0 || vec_idx !== 16'h0) begin
            nerr++; $display("FAIL reset_regs: got x=%h sig=%h idx=%0d expected 0", x, signature, vec_idx); end
        nchk++; if (busy !== 1'b0 || done !== 1'b0) begin
            nerr++; $display("FAIL reset_flags: got busy=%b done=%b expected 0 0", busy, done); end
        rst = 0;
        step;
    endtask

    task automatic test_directed;
        logic [22:0] s;
        z_const = 23'h7FFFFF;
        run_check(33'h1, 16'd1, 0, s);
        nchk++; if (s !== 23'h7FFFFF) begin nerr++; $display("FAIL one_vec_sig: got %h expected 7fffff", s); end
        run_check(33'h1, 16'd2, 0, s);
        nchk++; if (s !== 23'h000001) begin nerr++; $display("FAIL two_vec_sig: got %h expected 000001", s); end
        z_const = 23'($urandom);
        run_check(33'h0, 16'd3, 0, s);
        run_check(33'h1ABCD, 16'd0, 0, s);
    endtask

    task automatic test_random;
        logic [22:0] s;
        for (int r = 0; r < 6; r++) begin
            z_const = 23'($urandom);
            run_check({1'($urandom), 32'($urandom)}, 16'($urandom_range(1, 100)), 1'($urandom), s);
        end
    endtask

    task automatic test_golden_repeat;
        logic [22:0] s1, s2;
        run_check(33'h1ABCDEF01, 16'd1000, 1, s1);
        run_check(33'h1ABCDEF01, 16'd1000, 1, s2);
        nchk++; if (signature !== s1) begin nerr++; $display("FAIL golden_repeat: got %h expected %h", signature, s1); end
    endtask

    task automatic test_abort;
        logic [32:0] xe;
        logic [22:0] sig, held;
        z_pla = 1;
        seed = {1'($urandom), 32'($urandom)};
        count = 16'd10;
        start = 1;
        step;
        start = 0;
        xe = (seed == 0) ? 33'd1 : seed;
        sig = '0;
        for (int i = 0; i < 3; i++) begin
            sig = misr(sig, pla(xe));
            xe = lfsr(xe);
            step;
        end
        nchk++; if (vec_idx !== 16'd3 || x !== xe) begin nerr++; $display("FAIL abort_pre: got idx=%0d x=%h expected 3 %h", vec_idx, x, xe); end
        abort = 1;
        start = 1;
        step;
        abort = 0;
        start = 0;
        nchk++; if (busy !== 1'b0 || done !== 1'b0) begin nerr++; $display("FAIL abort_flags: got busy=%b done=%b expected 0 0", busy, done); end
        nchk++; if (x !== 33'h0 || vec_idx !== 16'h0) begin nerr++; $display("FAIL abort_clear: got x=%h idx=%0d expected 0 0", x, vec_idx); end
        nchk++; if (signature !== sig) begin nerr++; $display("FAIL abort_sig: got %h expected %h", signature, sig); end
        for (int i = 0; i < 5; i++) begin
            nchk++; if (busy !== 1'b0 || done !== 1'b0) begin nerr++; $display("FAIL abort_idle[%0d]: got busy=%b done=%b expected 0 0", i, busy, done); end
            step;
        end
        held = signature;
        abort = 1;
        step;
        abort = 0;
        nchk++; if (busy !== 1'b0 || done !== 1'b0 || signature !== held) begin
            nerr++; $display("FAIL abort_in_idle: got busy=%b done=%b sig=%h expected 0 0 %h", busy, done, signature, held); end
        z_pla = 0;
        seed = 33'h5;
        count = 16'd1;
        start = 1;
        abort = 1;
        step;
        start = 0;
        abort = 0;
        nchk++; if (busy !== 1'b1 || x !== 33'h5) begin nerr++; $display("FAIL abort_start: got busy=%b x=%h expected 1 5", busy, x); end
        step;
        nchk++; if (done !== 1'b1) begin nerr++; $display("FAIL abort_start_done: got %b expected 1", done); end
        step;
    endtask

    task automatic test_async_reset;
        z_pla = 1;
        seed = {1'($urandom), 32'($urandom)};
        count = 16'd10;
        start = 1;
        step;
        start = 0;
        repeat (5) step;
        nchk++; if (vec_idx !== 16'd5) begin nerr++; $display("FAIL rst_pre_idx: got %0d expected 5", vec_idx); end
        #2 rst = 1;
        #1;
        nchk++; if (x !== 33'h0 || signature !== 23'h0 || vec_idx !== 16'h0) begin
            nerr++; $display("FAIL async_rst_regs: got x=%h sig=%h idx=%0d expected 0", x, signature, vec_idx); end
        nchk++; if (busy !== 1'b0 || done !== 1'b0) begin
            nerr++; $display("FAIL async_rst_flags: got busy=%b done=%b expected 0 0", busy, done); end
        repeat (2) step;
        rst = 0;
        for (int i = 0; i < 12; i++) begin
            step;
            nchk++; if (busy !== 1'b0 || done !== 1'b0) begin nerr++; $display("FAIL rst_idle[%0d]: got busy=%b done=%b expected 0 0", i, busy, done); end
        end
    endtask

    task automatic test_max_count;
        logic [22:0] s;
        z_const = 23'($urandom);
        run_check({1'($urandom), 32'($urandom)}, 16'hFFFF, 0, s);
    endtask

    initial begin
        test_reset;
        test_directed;
        test_random;
        test_golden_repeat;
        test_abort;
        test_async_reset;
        test_max_count;
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
